apb_pwm_deadtime: RTL and testbench

APB3-programmable dead-time generator that sits directly downstream of the PWM controller. It consumes the single-ended `pwm_out` waveform and produces a non-overlapping complementary pair, `pwm_hi`/`pwm_lo`, for a half-bridge gate driver. Rising and falling dead-times are programmed independently. An optional external fault input forces both outputs low and holds them low until software clears the fault.

---
 rtl/apb_pwm_deadtime.sv | 117 +++++++++++
 tb/tb_apb_pwm_deadtime.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_pwm_deadtime.sv
// apb_pwm_deadtime: APB3 dead-time generator turning pwm_in into a non-overlapping pwm_hi/pwm_lo pair.
// Define PWM_DT_FAULT_EN to build the fault synchroniser, FAULT state, FAULT_IE and irq.
module apb_pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        pwm_in,
  input  logic        fault_in,
  output logic        pwm_hi,
  output logic        pwm_lo,
  output logic        irq
);
  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_DEAD = 3'd1, S_HI = 3'd2, S_LO = 3'd3, S_FAULT = 3'd4
  } state_t;
  state_t state, state_d;
  logic en, fault_ie, fault, fault_sync, target, target_d, load, hi_d, lo_d, wr, unused_ok;
  logic [DT_W-1:0] dt_rise, dt_fall, cnt, cnt_d;
  logic [31:0] dt_reg, rd_val;
  assign pready = 1'b1;
  assign wr = psel & penable & pwrite;
  assign irq = fault & fault_ie;
  assign unused_ok = ^{pwdata, fault_in};
`ifdef PWM_DT_FAULT_EN
  logic [1:0] sync;
  assign fault_sync = sync[1];
  // A W1C loses against a fault that is still present on the same edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync <= '0;
      fault <= 1'b0;
      fault_ie <= 1'b0;
    end else begin
      sync <= {sync[0], fault_in};
      fault <= fault_sync | (fault & ~(wr && paddr == 32'h8 && pwdata[0]));
      if (wr && paddr == 32'h0) fault_ie <= pwdata[1];
    end
  end
`else
  assign {fault_sync, fault, fault_ie} = 3'b000;
`endif
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      en <= 1'b0;
      dt_rise <= '0;
      dt_fall <= '0;
      prdata <= '0;
    end else begin
      if (wr && paddr == 32'h0) en <= pwdata[0];
      if (wr && paddr == 32'h4) begin
        dt_rise <= pwdata[DT_W-1:0];
        dt_fall <= pwdata[16 +: DT_W];
      end
      prdata <= (psel && !pwrite) ? rd_val : '0;
    end
  end
  always_comb begin
    dt_reg = '0;
    dt_reg[DT_W-1:0] = dt_rise;
    dt_reg[16 +: DT_W] = dt_fall;
    rd_val = paddr == 32'h0 ? {30'd0, fault_ie, en} :
             paddr == 32'h4 ? dt_reg :
             paddr == 32'h8 ? {25'd0, state, 2'd0, fault_sync, fault} : '0;
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= S_OFF;
      target <= 1'b0;
      cnt <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      state <= state_d;
      target <= target_d;
      cnt <= cnt_d;
      pwm_hi <= hi_d;
      pwm_lo <= lo_d;
    end
  end
  // Every load targets the current pwm_in, so one shared load path serves all states.
  always_comb begin
    state_d = state;
    target_d = target;
    cnt_d = cnt;
    load = 1'b0;
    if (fault_sync) state_d = S_FAULT;
    else if (state == S_FAULT) state_d = fault ? S_FAULT : S_OFF;
    else if (!en) state_d = S_OFF;
    else case (state)
      S_OFF: load = 1'b1;
      S_DEAD:
        if (pwm_in != target) load = 1'b1;
        else if (cnt == '0) state_d = target ? S_HI : S_LO;
        else cnt_d = cnt - DT_W'(1);
      S_HI: load = !pwm_in;
      S_LO: load = pwm_in;
      default: state_d = S_OFF;
    endcase
    if (load) begin
      state_d = S_DEAD;
      target_d = pwm_in;
      cnt_d = pwm_in ? dt_rise : dt_fall;
    end
  end
  always_comb begin
    hi_d = state_d == S_HI;
    lo_d = state_d == S_LO;
  end
endmodule

// File: tb/tb_apb_pwm_deadtime.sv
// tb_apb_pwm_deadtime: directed and random stimulus against a run-length model of the dead-time rules.
module tb_apb_pwm_deadtime;
  localparam int DT_W = 8;
`ifdef PWM_DT_FAULT_EN
  localparam logic [31:0] CTRL3 = 32'h3;
`else
  localparam logic [31:0] CTRL3 = 32'h1;
`endif
  logic pclk = 0, preset = 1, psel = 0, penable = 0, pwrite = 0, pwm_in = 0, fault_in = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [31:0] prdata;
  logic pready, pwm_hi, pwm_lo, irq;
  int checks = 0, errors = 0;
  logic chk_on = 0;
  always #5 pclk = ~pclk;
  apb_pwm_deadtime #(.DT_W(DT_W)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pwm_in(pwm_in), .fault_in(fault_in), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .irq(irq)
  );
  // Model: an output asserts once pwm_in has held its level for dead-time + 2 enabled samples.
  logic m_en, last;
  int m_dr, m_df, run;
  logic exp_hi, exp_lo;
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_en <= 0; m_dr <= 0; m_df <= 0; run <= 0; last <= 0;
    end else begin
      if (!m_en) run <= 0;
      else if (run == 0 || pwm_in != last) begin run <= 1; last <= pwm_in; end
      else if (run < 100000) run <= run + 1;
      if (psel && penable && pwrite && paddr == 32'h0) m_en <= pwdata[0];
      if (psel && penable && pwrite && paddr == 32'h4) begin
        m_dr <= int'(pwdata[7:0]);
        m_df <= int'(pwdata[23:16]);
      end
    end
  end
  assign exp_hi = last && run >= m_dr + 2;
  assign exp_lo = !last && run >= m_df + 2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge pclk);
    if (chk_on) begin
      chk("model_hi", 32'(pwm_hi), 32'(exp_hi));
      chk("model_lo", 32'(pwm_lo), 32'(exp_lo));
    end
    chk("overlap", 32'(pwm_hi & pwm_lo), 0);
  endtask
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    psel = 1; pwrite = 1; paddr = a; pwdata = d; penable = 0;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask
  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    psel = 1; pwrite = 0; paddr = a; penable = 0;
    step();
    penable = 1;
    step();
    d = prdata;
    psel = 0; penable = 0;
  endtask
  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) step();
  endtask
  task automatic cnt_low(input logic v, input int n, output int c);
    pwm_in = v;
    c = 0;
    repeat (n) begin
      step();
      if (v ? !pwm_hi : !pwm_lo) c++;
    end
  endtask
  initial begin
    logic [31:0] rd;
    int c, dr, df;
    repeat (2) @(negedge pclk);
    chk("rst_hi", 32'(pwm_hi), 0);
    chk("rst_lo", 32'(pwm_lo), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_prdata", prdata, 0);
    chk("pready", 32'(pready), 1);
    preset = 0;
    chk_on = 1;
    step();
    apb_rd(32'h0, rd); chk("rst_ctrl", rd, 0);
    apb_rd(32'h4, rd); chk("rst_dt", rd, 0);
    apb_rd(32'h8, rd); chk("rst_status", rd, 0);
    apb_wr(32'h4, 32'h00FF_00AB); apb_rd(32'h4, rd); chk("dt_rb", rd, 32'h00FF_00AB);
    apb_wr(32'h4, 32'hFFFF_FFFF); apb_rd(32'h4, rd); chk("dt_mask", rd, 32'h00FF_00FF);
    apb_wr(32'hC, 32'h1234); apb_rd(32'hC, rd); chk("unmapped", rd, 0);
    apb_wr(32'h100, 32'h1); apb_rd(32'h0, rd); chk("full_decode", rd, 0);
    apb_wr(32'h0, 32'h3); apb_rd(32'h0, rd); chk("ctrl_rb", rd, CTRL3);
    apb_wr(32'h0, 32'h0);
    // basic waveform: rise 3, fall 5, period 20 duty 8
    apb_wr(32'h4, {16'd5, 16'd3});
    apb_wr(32'h0, 32'h1);
    hold(0, 12);
    repeat (3) begin
      cnt_low(1, 8, c); chk("rise_dead", c, 4);
      cnt_low(0, 12, c); chk("fall_dead", c, 6);
    end
    hold(1, 8);
    chk("hi_before_dis", 32'(pwm_hi), 1);
    apb_wr(32'h0, 32'h0);
    step();
    chk("dis_hi", 32'(pwm_hi), 0);
    chk("dis_lo", 32'(pwm_lo), 0);
    apb_rd(32'h8, rd); chk("dis_state", rd, 0);
    // zero dead-time
    apb_wr(32'h4, 32'h0);
    apb_wr(32'h0, 32'h1);
    hold(0, 4);
    repeat (4) begin
      cnt_low(1, 3, c); chk("zero_rise", c, 1);
      cnt_low(0, 3, c); chk("zero_fall", c, 1);
    end
    // glitch absorption
    apb_wr(32'h0, 32'h0);
    apb_wr(32'h4, {16'd5, 16'd10});
    apb_wr(32'h0, 32'h1);
    hold(0, 10);
    cnt_low(1, 4, c); chk("glitch_hi", c, 4);
    cnt_low(0, 10, c); chk("glitch_lo", c, 6);
    // random dead-times and pwm patterns
    repeat (4) begin
      apb_wr(32'h0, 32'h0);
      dr = int'($urandom_range(0, 6));
      df = int'($urandom_range(0, 6));
      apb_wr(32'h4, (32'(df) << 16) | 32'(dr));
      apb_wr(32'h0, 32'h1);
      repeat (40) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    // fault path
    apb_wr(32'h0, 32'h0);
    apb_wr(32'h4, {16'd5, 16'd3});
    apb_wr(32'h0, 32'h3);
    hold(1, 12);
    chk("hi_pre_fault", 32'(pwm_hi), 1);
`ifdef PWM_DT_FAULT_EN
    chk_on = 0;
    fault_in = 1;
    step(); step();
    fault_in = 0;
    step();
    chk("fault_hi", 32'(pwm_hi), 0);
    chk("fault_irq", 32'(irq), 1);
    hold(1, 3);
    apb_rd(32'h8, rd); chk("status_fault", rd, 32'h41);
    apb_wr(32'h8, 32'h1);
    apb_rd(32'h8, rd); chk("status_off", rd, 0);
    chk("irq_clr", 32'(irq), 0);
    apb_rd(32'h8, rd); chk("status_dead", rd, 32'h10);
    fault_in = 1;
    hold(1, 4);
    apb_wr(32'h8, 32'h1);
    apb_rd(32'h8, rd); chk("w1c_held", rd, 32'h43);
    fault_in = 0;
    hold(1, 4);
    apb_wr(32'h8, 32'h1);
    apb_wr(32'h0, 32'h0);
    hold(0, 4);
    chk_on = 1;
    apb_wr(32'h0, 32'h1);
    hold(0, 12);
`else
    fault_in = 1;
    hold(1, 6);
    chk("nofault_irq", 32'(irq), 0);
    apb_rd(32'h8, rd); chk("nofault_status", rd, 32'h20);
    fault_in = 0;
`endif
    // asynchronous reset while driving high side
    hold(1, 8);
    chk("hi_pre_rst", 32'(pwm_hi), 1);
    #2 preset = 1;
    #1;
    chk("arst_hi", 32'(pwm_hi), 0);
    chk("arst_lo", 32'(pwm_lo), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_prdata", prdata, 0);
    @(negedge pclk);
    preset = 0;
    hold(1, 5);
    hold(0, 5);
    chk("post_rst_hi", 32'(pwm_hi), 0);
    chk("post_rst_lo", 32'(pwm_lo), 0);
    apb_rd(32'h0, rd); chk("post_rst_ctrl", rd, 0);
    apb_rd(32'h4, rd); chk("post_rst_dt", rd, 0);
    apb_rd(32'h8, rd); chk("post_rst_status", rd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
